// File: rtl/bev_pkg.sv
// Shared definitions for the beverage vending datapath: widths, coin and
// price constants, and the change-dispenser state encoding.
package bev_pkg;

    // Change amounts and the dispenser's remainder register
    localparam int WIDTH = 10;

    // Coin values in cents, largest first (greedy payout order)
    localparam int COIN_Q = 25;
    localparam int COIN_D = 10;
    localparam int COIN_N = 5;

    // Beverage prices in cents, shared with the vend stage
    localparam int PRICE_WATER = 50;
    localparam int PRICE_COLA  = 65;
    localparam int PRICE_JUICE = 85;

    typedef enum logic {
        IDLE,
        DISPENSE
    } disp_state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vend stage (master) and the change
// dispenser (slave): vend pulse and change value in, coin pulses and
// status out.
interface change_dispenser_if #(
    parameter int W = bev_pkg::WIDTH
);
    logic         load;
    logic [W-1:0] change_in;
    logic         busy;
    logic         coin_q;
    logic         coin_d;
    logic         coin_n;
    logic         done;
    logic         short_pay;
    logic         overrun;

    modport master (
        output load, change_in,
        input  busy, coin_q, coin_d, coin_n, done, short_pay, overrun
    );

    modport slave (
        input  load, change_in,
        output busy, coin_q, coin_d, coin_n, done, short_pay, overrun
    );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy coin picker: given the remaining change, choose the
// largest coin that fits, report the remainder after paying it, or flag
// termination when no coin fits.
module coin_select
    import bev_pkg::*;
#(
    parameter int WIDTH  = bev_pkg::WIDTH,
    parameter int COIN_Q = bev_pkg::COIN_Q,
    parameter int COIN_D = bev_pkg::COIN_D,
    parameter int COIN_N = bev_pkg::COIN_N
) (
    input  logic [WIDTH-1:0] rem,
    output logic             pick_q,
    output logic             pick_d,
    output logic             pick_n,
    output logic [WIDTH-1:0] next_rem,
    output logic             term
);

    localparam logic [WIDTH-1:0] Q_W = WIDTH'(COIN_Q);
    localparam logic [WIDTH-1:0] D_W = WIDTH'(COIN_D);
    localparam logic [WIDTH-1:0] N_W = WIDTH'(COIN_N);

    // Pick the largest coin not exceeding rem; subtraction only when it fits
    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path leaves one unassigned (no latch).
        pick_q   = 1'b0;
        pick_d   = 1'b0;
        pick_n   = 1'b0;
        next_rem = rem;
        term     = 1'b0;
        if (rem >= Q_W) begin
            pick_q   = 1'b1;
            next_rem = rem - Q_W;
        end else if (rem >= D_W) begin
            pick_d   = 1'b1;
            next_rem = rem - D_W;
        end else if (rem >= N_W) begin
            pick_n   = 1'b1;
            next_rem = rem - N_W;
        end else begin
            term     = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts a change value on a vend pulse and pays it out
// one coin pulse per cycle (quarter, dime, nickel greedy order), then pulses
// done with short_pay flagging an unpayable 1..4 cent residue.
// Optional macro LOAD_QUEUE_EN adds a one-entry holding register so a load
// arriving mid-sequence is paid out next instead of being dropped.
module change_dispenser
    import bev_pkg::*;
#(
    parameter int WIDTH  = bev_pkg::WIDTH,
    parameter int COIN_Q = bev_pkg::COIN_Q,
    parameter int COIN_D = bev_pkg::COIN_D,
    parameter int COIN_N = bev_pkg::COIN_N
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);

    disp_state_e      state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             coin_q_q, coin_q_d;
    logic             coin_d_q, coin_d_d;
    logic             coin_n_q, coin_n_d;
    logic             done_q, done_d;
    logic             short_pay_q, short_pay_d;
    logic             overrun_q, overrun_d;
`ifdef LOAD_QUEUE_EN
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
`endif

    logic             pick_q, pick_d, pick_n, term;
    logic [WIDTH-1:0] next_rem;

    coin_select #(
        .WIDTH  (WIDTH),
        .COIN_Q (COIN_Q),
        .COIN_D (COIN_D),
        .COIN_N (COIN_N)
    ) u_coin_select (
        .rem      (rem_q),
        .pick_q   (pick_q),
        .pick_d   (pick_d),
        .pick_n   (pick_n),
        .next_rem (next_rem),
        .term     (term)
    );

    // Next-state, remainder, pending-slot and registered-output decode
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        busy_d      = busy_q;
        coin_q_d    = 1'b0;
        coin_d_d    = 1'b0;
        coin_n_d    = 1'b0;
        done_d      = 1'b0;
        short_pay_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef LOAD_QUEUE_EN
        pend_valid_d = pend_valid_q;
        pend_val_d   = pend_val_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef LOAD_QUEUE_EN
                // A value captured on the previous terminating edge launches first
                if (pend_valid_q) begin
                    rem_d        = pend_val_q;
                    pend_valid_d = 1'b0;
                    state_d      = DISPENSE;
                    busy_d       = 1'b1;
                    overrun_d    = bus.load;
                end else
`endif
                if (bus.load) begin
                    rem_d   = bus.change_in;
                    state_d = DISPENSE;
                    busy_d  = 1'b1;
                end
            end
            DISPENSE: begin
                coin_q_d = pick_q;
                coin_d_d = pick_d;
                coin_n_d = pick_n;
                rem_d    = next_rem;
                if (term) begin
                    done_d      = 1'b1;
                    short_pay_d = (rem_q != '0);
`ifdef LOAD_QUEUE_EN
                    // Chain straight into the held value without leaving DISPENSE
                    if (pend_valid_q) begin
                        rem_d        = pend_val_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
`endif
                end
`ifdef LOAD_QUEUE_EN
                if (bus.load) begin
                    if (pend_valid_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_val_d   = bus.change_in;
                    end
                end
`else
                overrun_d = bus.load;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; synchronous reset wins over load
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            coin_q_q    <= 1'b0;
            coin_d_q    <= 1'b0;
            coin_n_q    <= 1'b0;
            done_q      <= 1'b0;
            short_pay_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef LOAD_QUEUE_EN
            pend_valid_q <= 1'b0;
            pend_val_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            coin_q_q    <= coin_q_d;
            coin_d_q    <= coin_d_d;
            coin_n_q    <= coin_n_d;
            done_q      <= done_d;
            short_pay_q <= short_pay_d;
            overrun_q   <= overrun_d;
`ifdef LOAD_QUEUE_EN
            pend_valid_q <= pend_valid_d;
            pend_val_q   <= pend_val_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.coin_q    = coin_q_q;
    assign bus.coin_d    = coin_d_q;
    assign bus.coin_n    = coin_n_q;
    assign bus.done      = done_q;
    assign bus.short_pay = short_pay_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus computes each payout with
// division/modulo and queues expected coin/done/overrun events stamped with
// the clock edge they must follow; a monitor compares on every falling edge.
module tb_change_dispenser;
    import bev_pkg::*;

    localparam int K_NONE = 0;
    localparam int K_Q    = 1;
    localparam int K_D    = 2;
    localparam int K_N    = 3;
    localparam int K_DONE = 4;
    localparam int K_MULT = 5;

    typedef struct {
        int ed;
        int kind;
        bit sp;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    change_dispenser_if #(.W(WIDTH)) bus ();

    change_dispenser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_pass   = 0;

    ev_t exp_coin[$];
    int  exp_ovr[$];
    bit  busy_exp[int];

    // Reference model state: last terminating edge of the active sequence
    int  ds_end     = 0;
    bit  pend_valid = 1'b0;
    int  pend_val   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s edge %0d: got %0d expected %0d", name, edge_cnt, got, expv);
    endtask

    // Sequence accepted at edge e paying v cents: coins follow e+1.., done after
    function automatic void schedule(input int e, input int v);
        int nq, nd, nn, r, t;
        nq = v / COIN_Q;
        r  = v % COIN_Q;
        nd = r / COIN_D;
        r  = r % COIN_D;
        nn = r / COIN_N;
        r  = r % COIN_N;
        t  = e;
        for (int i = 0; i < nq; i++) begin t++; exp_coin.push_back('{t, K_Q, 1'b0}); end
        for (int i = 0; i < nd; i++) begin t++; exp_coin.push_back('{t, K_D, 1'b0}); end
        for (int i = 0; i < nn; i++) begin t++; exp_coin.push_back('{t, K_N, 1'b0}); end
        exp_coin.push_back('{t + 1, K_DONE, (r != 0)});
        ds_end = t + 1;
    endfunction

    function automatic void model_step(input int e, input bit r, input bit l, input int v);
        bit in_ds, pv0;
        if (r) begin
            while (exp_coin.size() > 0 && exp_coin[$].ed >= e) void'(exp_coin.pop_back());
            while (exp_ovr.size() > 0 && exp_ovr[$] >= e) void'(exp_ovr.pop_back());
            ds_end      = 0;
            pend_valid  = 1'b0;
            busy_exp[e] = 1'b0;
            return;
        end
        in_ds = (e <= ds_end);
        pv0   = pend_valid;
`ifdef LOAD_QUEUE_EN
        if (in_ds) begin
            if (e == ds_end && pv0) begin
                schedule(e, pend_val);
                pend_valid = 1'b0;
            end
            if (l) begin
                if (pv0) exp_ovr.push_back(e);
                else begin
                    pend_valid = 1'b1;
                    pend_val   = v;
                end
            end
        end else begin
            if (pv0) begin
                schedule(e, pend_val);
                pend_valid = 1'b0;
                if (l) exp_ovr.push_back(e);
            end else if (l) begin
                schedule(e, v);
            end
        end
`else
        if (in_ds) begin
            if (l) exp_ovr.push_back(e);
        end else if (l) begin
            schedule(e, v);
        end
`endif
        busy_exp[e] = (ds_end > e);
    endfunction

    // Drive inputs for the next edge, advance the model, then wait that edge
    task automatic step(input bit r, input bit l, input int v);
        logic [31:0] vv;
        vv            = v;
        rst           = r;
        bus.load      = l;
        bus.change_in = vv[WIDTH-1:0];
        model_step(edge_cnt + 1, r, l, v);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    // Monitor: compare registered outputs against the scoreboard every cycle
    always @(negedge clk) begin
        int  n, obs_kind, exp_kind, cnt, exp_o;
        bit  exp_sp;
        ev_t ev;
        n = edge_cnt;
        if (n >= 1) begin
            cnt = int'(bus.coin_q === 1'b1) + int'(bus.coin_d === 1'b1)
                + int'(bus.coin_n === 1'b1) + int'(bus.done === 1'b1);
            if (cnt > 1)                  obs_kind = K_MULT;
            else if (bus.coin_q === 1'b1) obs_kind = K_Q;
            else if (bus.coin_d === 1'b1) obs_kind = K_D;
            else if (bus.coin_n === 1'b1) obs_kind = K_N;
            else if (bus.done === 1'b1)   obs_kind = K_DONE;
            else                          obs_kind = K_NONE;

            exp_kind = K_NONE;
            exp_sp   = 1'b0;
            if (exp_coin.size() > 0 && exp_coin[0].ed == n) begin
                ev       = exp_coin.pop_front();
                exp_kind = ev.kind;
                exp_sp   = ev.sp;
            end
            if (exp_kind != K_NONE || obs_kind != K_NONE) check("coin_event", obs_kind, exp_kind);
            if (exp_kind == K_DONE && obs_kind == K_DONE) check("short_pay", {31'd0, bus.short_pay}, {31'd0, exp_sp});

            exp_o = 0;
            if (exp_ovr.size() > 0 && exp_ovr[0] == n) begin
                void'(exp_ovr.pop_front());
                exp_o = 1;
            end
            if (exp_o != 0 || bus.overrun !== 1'b0) check("overrun", {31'd0, bus.overrun}, exp_o);

            if (busy_exp.exists(n)) check("busy", {31'd0, bus.busy}, {31'd0, busy_exp[n]});
        end
    end

    initial begin
        int r_sel, v;
        bit r, l;
        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.change_in = '0;

        // Reset held with a load present: nothing may start
        step(1'b1, 1'b1, 40);
        step(1'b1, 1'b1, 40);
        idle(3);
        // 40 cents: Q, D, N, done
        step(1'b0, 1'b1, 40);  idle(6);
        // Zero change: done only
        step(1'b0, 1'b1, 0);   idle(3);
        // 17 cents: D, N, done with residue
        step(1'b0, 1'b1, 17);  idle(5);
        // Loads during a sequence
        step(1'b0, 1'b1, 75);  idle(1);
        step(1'b0, 1'b1, 10);
        step(1'b0, 1'b1, 20);  idle(10);
        // Reset mid-sequence, then a fresh sequence
        step(1'b0, 1'b1, 100); idle(1);
        step(1'b1, 1'b0, 0);   idle(1);
        step(1'b0, 1'b1, 30);  idle(6);
        // Maximum input
        step(1'b0, 1'b1, 1023); idle(46);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            r     = ($urandom_range(0, 199) == 0);
            l     = ($urandom_range(0, 3) == 0);
            r_sel = $urandom_range(0, 9);
            if (r_sel == 0)      v = 0;
            else if (r_sel == 1) v = 1023;
            else                 v = $urandom_range(0, 150);
            step(r, l, v);
        end
        idle(60);

        check("coin_queue_drained", exp_coin.size(), 0);
        check("overrun_queue_drained", exp_ovr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
